// File: rtl/pipeline_controller.sv
// Purpose : hazard/sequencing control for the 5-stage core: stall/flush enables, EX forwarding, dmem wait.
// Latency : stall/flush/forward outputs are combinational; state and counters update on the next clk edge.
// Backpress: a not-ready data memory freezes every pipeline register; too long a wait latches HALT until rst.
//
// Ports
//   clk, rst                      core clock, synchronous active-high reset
//   ID_*                          source regs / use bits / branch info of the instruction in ID
//   EX_*, MEM_*, WB_*             destination regs and control bits of the downstream stages
//   dmem_ready_i                  data memory completes the access currently in MEM
//   *_stall_o                     hold the PC or pipeline register
//   *_flush_o                     load a bubble into the pipeline register
//   EX_forwardA_o/EX_forwardB_o   00 none, 01 from MEM, 10 from WB
//   mem_timeout_o                 sticky: memory never became ready, controller halted
//   stall_cycles_o/flush_count_o  free-running debug counters, wrap at 2^CNT_WIDTH
module pipeline_controller #(
   parameter int unsigned MEM_TIMEOUT = 64,
   parameter int unsigned CNT_WIDTH   = 32
) (
   input  logic                 clk,
   input  logic                 rst,

   input  logic [4:0]           ID_rs1_i,
   input  logic [4:0]           ID_rs2_i,
   input  logic                 ID_use_rs1_i,
   input  logic                 ID_use_rs2_i,
   input  logic                 ID_is_branch_i,
   input  logic                 ID_PCSrc_i,

   input  logic [4:0]           EX_rs1_i,
   input  logic [4:0]           EX_rs2_i,
   input  logic [4:0]           EX_rd_i,
   input  logic                 EX_RegWrite_i,
   input  logic                 EX_MemRead_i,

   input  logic [4:0]           MEM_rd_i,
   input  logic                 MEM_RegWrite_i,
   input  logic                 MEM_MemRead_i,
   input  logic                 MEM_MemWrite_i,

   input  logic [4:0]           WB_rd_i,
   input  logic                 WB_RegWrite_i,

   input  logic                 dmem_ready_i,

   output logic                 pc_stall_o,
   output logic                 IF_ID_stall_o,
   output logic                 ID_EX_stall_o,
   output logic                 EX_MEM_stall_o,
   output logic                 IF_ID_flush_o,
   output logic                 ID_EX_flush_o,
   output logic                 MEM_WB_flush_o,
   output logic [1:0]           EX_forwardA_o,
   output logic [1:0]           EX_forwardB_o,
   output logic                 mem_timeout_o,
   output logic [CNT_WIDTH-1:0] stall_cycles_o,
   output logic [CNT_WIDTH-1:0] flush_count_o
);

   // Wait counter holds 0..MEM_TIMEOUT without overflow.
   localparam int unsigned      WCW       = $clog2(MEM_TIMEOUT + 2);
   localparam logic [WCW-1:0]   TIMEOUT_W = WCW'(MEM_TIMEOUT);
   localparam logic [WCW-1:0]   ONE_W     = WCW'(1);

   localparam logic [1:0] FWD_NONE = 2'b00;
   localparam logic [1:0] FWD_MEM  = 2'b01;
   localparam logic [1:0] FWD_WB   = 2'b10;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_HALT     = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [WCW-1:0]       r_wait_cnt;
   logic [WCW-1:0]       w_wait_cnt_nxt;
   logic [WCW-1:0]       w_wait_inc;
   logic                 r_mem_timeout;
   logic                 w_mem_timeout_nxt;
   logic [CNT_WIDTH-1:0] r_stall_cycles;
   logic [CNT_WIDTH-1:0] r_flush_count;

   logic                 w_mem_req;
   logic                 w_mem_block;
   logic                 w_ex_rd_hit;
   logic                 w_mem_rd_hit;
   logic                 w_load_use;
   logic                 w_branch_haz;
   logic                 w_hazard;

   // Raw (not reset-gated) control decisions of the current cycle.
   logic                 w_freeze;     // whole pipeline held, MEM/WB bubbled
   logic                 w_hz_stall;   // PC and IF/ID held, ID/EX bubbled
   logic                 w_redirect;   // wrong-path fetch in IF/ID squashed

   // Does the ID instruction read register rd? x0 never creates a dependency.
   function automatic logic f_id_reads(
      input logic [4:0] rd,
      input logic [4:0] rs1,
      input logic [4:0] rs2,
      input logic       use1,
      input logic       use2
   );
      return (rd != 5'd0) && ((use1 && (rs1 == rd)) || (use2 && (rs2 == rd)));
   endfunction

   // A load in MEM has no data yet, so only ALU results are taken from MEM.
   function automatic logic [1:0] f_fwd_sel(
      input logic [4:0] src,
      input logic [4:0] mem_rd,
      input logic       mem_rw,
      input logic       mem_mr,
      input logic [4:0] wb_rd,
      input logic       wb_rw
   );
      if (src == 5'd0) begin
         return FWD_NONE;
      end else if (mem_rw && !mem_mr && (mem_rd == src)) begin
         return FWD_MEM;
      end else if (wb_rw && (wb_rd == src)) begin
         return FWD_WB;
      end
      return FWD_NONE;
   endfunction

   // ---------------------------------------------------------------- hazards
   always_comb begin
      w_mem_req    = MEM_MemRead_i | MEM_MemWrite_i;
      w_mem_block  = w_mem_req & ~dmem_ready_i;
      w_ex_rd_hit  = f_id_reads(EX_rd_i,  ID_rs1_i, ID_rs2_i, ID_use_rs1_i, ID_use_rs2_i);
      w_mem_rd_hit = f_id_reads(MEM_rd_i, ID_rs1_i, ID_rs2_i, ID_use_rs1_i, ID_use_rs2_i);
      w_load_use   = EX_MemRead_i & w_ex_rd_hit;
      // Branches resolve in ID, so they also wait for an EX ALU result and
      // for a load that is still in MEM (second bubble of branch-after-load).
      w_branch_haz = ID_is_branch_i &
                     ((EX_RegWrite_i & w_ex_rd_hit) |
                      (MEM_RegWrite_i & MEM_MemRead_i & w_mem_rd_hit));
      w_hazard     = w_load_use | w_branch_haz;
   end

   // ------------------------------------------------------ FSM next state/out
   always_comb begin
      w_state_nxt       = r_state;
      w_wait_cnt_nxt    = r_wait_cnt;
      w_mem_timeout_nxt = r_mem_timeout;
      w_freeze          = 1'b0;
      w_hz_stall        = 1'b0;
      w_redirect        = 1'b0;
      // Number of consecutive not-ready cycles including the current one.
      w_wait_inc        = r_wait_cnt + ONE_W;

      unique case (r_state)
         ST_RUN: begin
            if (w_mem_block) begin
               // Memory stall masks any ID hazard or redirect this cycle.
               w_freeze = 1'b1;
               if (TIMEOUT_W <= ONE_W) begin
                  w_state_nxt       = ST_HALT;
                  w_mem_timeout_nxt = 1'b1;
               end else begin
                  w_state_nxt    = ST_MEM_WAIT;
                  w_wait_cnt_nxt = ONE_W;
               end
            end else if (w_hazard) begin
               // Branch not resolved yet, so a pending redirect is not honoured.
               w_hz_stall = 1'b1;
            end else if (ID_PCSrc_i) begin
               w_redirect = 1'b1;
            end
         end

         ST_MEM_WAIT: begin
            if (!dmem_ready_i) begin
               w_freeze = 1'b1;
               if (w_wait_inc >= TIMEOUT_W) begin
                  w_state_nxt       = ST_HALT;
                  w_mem_timeout_nxt = 1'b1;
               end else begin
                  w_wait_cnt_nxt = w_wait_inc;
               end
            end else begin
               // Release cycle: the memory result lands, ID is re-evaluated.
               w_state_nxt    = ST_RUN;
               w_wait_cnt_nxt = '0;
               if (w_hazard) begin
                  w_hz_stall = 1'b1;
               end else if (ID_PCSrc_i) begin
                  w_redirect = 1'b1;
               end
            end
         end

         ST_HALT: begin
            w_freeze = 1'b1;
         end

         default: begin
            w_state_nxt    = ST_RUN;
            w_wait_cnt_nxt = '0;
         end
      endcase
   end

   // --------------------------------------------------------------- outputs
   // Everything is forced inactive while rst is high.
   assign pc_stall_o     = ~rst & (w_freeze | w_hz_stall);
   assign IF_ID_stall_o  = ~rst & (w_freeze | w_hz_stall);
   assign ID_EX_stall_o  = ~rst & w_freeze;
   assign EX_MEM_stall_o = ~rst & w_freeze;
   assign MEM_WB_flush_o = ~rst & w_freeze;
   assign ID_EX_flush_o  = ~rst & w_hz_stall;
   assign IF_ID_flush_o  = ~rst & w_redirect;

   assign EX_forwardA_o  = rst ? FWD_NONE :
                           f_fwd_sel(EX_rs1_i, MEM_rd_i, MEM_RegWrite_i, MEM_MemRead_i,
                                     WB_rd_i, WB_RegWrite_i);
   assign EX_forwardB_o  = rst ? FWD_NONE :
                           f_fwd_sel(EX_rs2_i, MEM_rd_i, MEM_RegWrite_i, MEM_MemRead_i,
                                     WB_rd_i, WB_RegWrite_i);

   assign mem_timeout_o  = r_mem_timeout;
   assign stall_cycles_o = r_stall_cycles;
   assign flush_count_o  = r_flush_count;

   // ------------------------------------------------------------- registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= ST_RUN;
         r_wait_cnt     <= '0;
         r_mem_timeout  <= 1'b0;
         r_stall_cycles <= '0;
         r_flush_count  <= '0;
      end else begin
         r_state        <= w_state_nxt;
         r_wait_cnt     <= w_wait_cnt_nxt;
         r_mem_timeout  <= w_mem_timeout_nxt;
         r_stall_cycles <= r_stall_cycles + CNT_WIDTH'(pc_stall_o);
         // One count per flushing cycle, even when both front flushes fire.
         r_flush_count  <= r_flush_count + CNT_WIDTH'(IF_ID_flush_o | ID_EX_flush_o);
      end
   end

endmodule

// File: tb/tb_pipeline_controller.sv
// Purpose : directed bench for pipeline_controller with a cycle-level reference model.
// Latency : model compares every falling edge; directed literals are read 1 time unit after the rising edge.
// Backpress: memory waits, timeout/HALT and reset recovery are all exercised.
module tb_pipeline_controller;

   localparam int TO = 4;
   localparam int CW = 8;

   logic          clk;
   logic          rst;
   logic [4:0]    ID_rs1_i, ID_rs2_i;
   logic          ID_use_rs1_i, ID_use_rs2_i, ID_is_branch_i, ID_PCSrc_i;
   logic [4:0]    EX_rs1_i, EX_rs2_i, EX_rd_i;
   logic          EX_RegWrite_i, EX_MemRead_i;
   logic [4:0]    MEM_rd_i;
   logic          MEM_RegWrite_i, MEM_MemRead_i, MEM_MemWrite_i;
   logic [4:0]    WB_rd_i;
   logic          WB_RegWrite_i;
   logic          dmem_ready_i;
   logic          pc_stall_o, IF_ID_stall_o, ID_EX_stall_o, EX_MEM_stall_o;
   logic          IF_ID_flush_o, ID_EX_flush_o, MEM_WB_flush_o;
   logic [1:0]    EX_forwardA_o, EX_forwardB_o;
   logic          mem_timeout_o;
   logic [CW-1:0] stall_cycles_o, flush_count_o;

   int n_checks = 0;
   int n_pass   = 0;

   pipeline_controller #(.MEM_TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst),
      .ID_rs1_i(ID_rs1_i), .ID_rs2_i(ID_rs2_i),
      .ID_use_rs1_i(ID_use_rs1_i), .ID_use_rs2_i(ID_use_rs2_i),
      .ID_is_branch_i(ID_is_branch_i), .ID_PCSrc_i(ID_PCSrc_i),
      .EX_rs1_i(EX_rs1_i), .EX_rs2_i(EX_rs2_i), .EX_rd_i(EX_rd_i),
      .EX_RegWrite_i(EX_RegWrite_i), .EX_MemRead_i(EX_MemRead_i),
      .MEM_rd_i(MEM_rd_i), .MEM_RegWrite_i(MEM_RegWrite_i),
      .MEM_MemRead_i(MEM_MemRead_i), .MEM_MemWrite_i(MEM_MemWrite_i),
      .WB_rd_i(WB_rd_i), .WB_RegWrite_i(WB_RegWrite_i),
      .dmem_ready_i(dmem_ready_i),
      .pc_stall_o(pc_stall_o), .IF_ID_stall_o(IF_ID_stall_o),
      .ID_EX_stall_o(ID_EX_stall_o), .EX_MEM_stall_o(EX_MEM_stall_o),
      .IF_ID_flush_o(IF_ID_flush_o), .ID_EX_flush_o(ID_EX_flush_o),
      .MEM_WB_flush_o(MEM_WB_flush_o),
      .EX_forwardA_o(EX_forwardA_o), .EX_forwardB_o(EX_forwardB_o),
      .mem_timeout_o(mem_timeout_o),
      .stall_cycles_o(stall_cycles_o), .flush_count_o(flush_count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, got, exp);
   endtask

   task automatic idle();
      ID_rs1_i = 0; ID_rs2_i = 0; ID_use_rs1_i = 0; ID_use_rs2_i = 0;
      ID_is_branch_i = 0; ID_PCSrc_i = 0;
      EX_rs1_i = 0; EX_rs2_i = 0; EX_rd_i = 0; EX_RegWrite_i = 0; EX_MemRead_i = 0;
      MEM_rd_i = 0; MEM_RegWrite_i = 0; MEM_MemRead_i = 0; MEM_MemWrite_i = 0;
      WB_rd_i = 0; WB_RegWrite_i = 0;
      dmem_ready_i = 1;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // ------------------------------------------------------ reference model
   function automatic bit id_reads(input logic [4:0] r);
      return (r != 5'd0) && ((ID_use_rs1_i && ID_rs1_i == r) || (ID_use_rs2_i && ID_rs2_i == r));
   endfunction

   function automatic int fwd(input logic [4:0] src);
      if (src != 0 && MEM_RegWrite_i && !MEM_MemRead_i && MEM_rd_i == src) return 1;
      if (src != 0 && WB_RegWrite_i && WB_rd_i == src) return 2;
      return 0;
   endfunction

   initial begin
      bit m_halt, m_wait, m_to;
      int m_nr, m_sc, m_fc;
      bit frz, hz, redir, mreq, nr;
      m_halt = 0; m_wait = 0; m_to = 0; m_nr = 0; m_sc = 0; m_fc = 0;
      @(posedge clk);
      forever begin
         @(negedge clk);
         frz = 0; hz = 0; redir = 0;
         mreq = MEM_MemRead_i | MEM_MemWrite_i;
         nr   = !dmem_ready_i;
         if (!rst) begin
            if (m_halt || (nr && (mreq || m_wait))) frz = 1;
            else if ((EX_MemRead_i && id_reads(EX_rd_i)) ||
                     (ID_is_branch_i && ((EX_RegWrite_i && id_reads(EX_rd_i)) ||
                                         (MEM_RegWrite_i && MEM_MemRead_i && id_reads(MEM_rd_i)))))
               hz = 1;
            else if (ID_PCSrc_i) redir = 1;
         end
         chk("m_pc_stall",     32'(pc_stall_o),     32'(frz | hz));
         chk("m_if_id_stall",  32'(IF_ID_stall_o),  32'(frz | hz));
         chk("m_id_ex_stall",  32'(ID_EX_stall_o),  32'(frz));
         chk("m_ex_mem_stall", 32'(EX_MEM_stall_o), 32'(frz));
         chk("m_mem_wb_flush", 32'(MEM_WB_flush_o), 32'(frz));
         chk("m_id_ex_flush",  32'(ID_EX_flush_o),  32'(hz));
         chk("m_if_id_flush",  32'(IF_ID_flush_o),  32'(redir));
         chk("m_fwdA",         32'(EX_forwardA_o),  rst ? 0 : fwd(EX_rs1_i));
         chk("m_fwdB",         32'(EX_forwardB_o),  rst ? 0 : fwd(EX_rs2_i));
         chk("m_timeout",      32'(mem_timeout_o),  32'(m_to));
         chk("m_stall_cnt",    32'(stall_cycles_o), m_sc);
         chk("m_flush_cnt",    32'(flush_count_o),  m_fc);
         if (rst) begin
            m_halt = 0; m_wait = 0; m_to = 0; m_nr = 0; m_sc = 0; m_fc = 0;
         end else begin
            m_sc = (m_sc + int'(frz | hz)) % (1 << CW);
            m_fc = (m_fc + int'(hz | redir)) % (1 << CW);
            if (!m_halt) begin
               if (frz) begin
                  m_nr++;
                  m_wait = 1;
                  if (m_nr >= TO) begin m_halt = 1; m_to = 1; end
               end else begin
                  m_nr = 0; m_wait = 0;
               end
            end
         end
      end
   end

   task automatic fwd_case(input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] mrd, input logic [4:0] wrd,
                           input logic mrw, input logic mmr, input logic wrw,
                           input int ea, input int eb, input string nm);
      cyc(); idle();
      EX_rs1_i = rs1; EX_rs2_i = rs2; MEM_rd_i = mrd; WB_rd_i = wrd;
      MEM_RegWrite_i = mrw; MEM_MemRead_i = mmr; WB_RegWrite_i = wrw;
      #1;
      chk({nm, "_A"}, 32'(EX_forwardA_o), ea);
      chk({nm, "_B"}, 32'(EX_forwardB_o), eb);
   endtask

   // ------------------------------------------------------ directed stimulus
   initial begin
      rst = 1; idle();
      cyc(); cyc();
      // Activity during reset must not leak to the outputs.
      EX_MemRead_i = 1; EX_RegWrite_i = 1; EX_rd_i = 5; ID_use_rs1_i = 1; ID_rs1_i = 5;
      MEM_MemRead_i = 1; dmem_ready_i = 0; EX_rs1_i = 5; WB_RegWrite_i = 1; WB_rd_i = 5;
      #1;
      chk("rst_pc_stall", 32'(pc_stall_o), 0);
      chk("rst_mem_wb_flush", 32'(MEM_WB_flush_o), 0);
      chk("rst_id_ex_flush", 32'(ID_EX_flush_o), 0);
      chk("rst_fwdA", 32'(EX_forwardA_o), 0);
      cyc(); rst = 0; idle(); #1;
      chk("rst_stall_cnt", 32'(stall_cycles_o), 0);
      chk("rst_timeout", 32'(mem_timeout_o), 0);

      // Load-use: exactly one bubble.
      cyc(); EX_MemRead_i = 1; EX_RegWrite_i = 1; EX_rd_i = 5; ID_use_rs1_i = 1; ID_rs1_i = 5; #1;
      chk("lu_pc_stall", 32'(pc_stall_o), 1);
      chk("lu_if_id_stall", 32'(IF_ID_stall_o), 1);
      chk("lu_id_ex_flush", 32'(ID_EX_flush_o), 1);
      chk("lu_id_ex_stall", 32'(ID_EX_stall_o), 0);
      cyc(); idle(); #1;
      chk("lu_pc_stall_after", 32'(pc_stall_o), 0);
      chk("lu_stall_cnt", 32'(stall_cycles_o), 1);
      chk("lu_flush_cnt", 32'(flush_count_o), 1);

      // Forwarding selects.
      fwd_case(3, 3, 3, 3, 1, 0, 1, 1, 1, "fwd_mem");
      fwd_case(3, 3, 3, 3, 0, 0, 1, 2, 2, "fwd_wb");
      fwd_case(0, 0, 0, 0, 1, 0, 1, 0, 0, "fwd_x0");
      fwd_case(3, 4, 3, 4, 1, 0, 1, 1, 2, "fwd_mix");
      fwd_case(6, 6, 6, 6, 1, 1, 1, 2, 2, "fwd_mem_load");

      // Memory wait of 3 cycles, first cycle also has load-use and redirect.
      cyc(); idle();
      MEM_MemRead_i = 1; dmem_ready_i = 0;
      EX_MemRead_i = 1; EX_rd_i = 5; ID_use_rs1_i = 1; ID_rs1_i = 5; ID_PCSrc_i = 1; #1;
      chk("sim_pc_stall", 32'(pc_stall_o), 1);
      chk("sim_ex_mem_stall", 32'(EX_MEM_stall_o), 1);
      chk("sim_mem_wb_flush", 32'(MEM_WB_flush_o), 1);
      chk("sim_id_ex_flush", 32'(ID_EX_flush_o), 0);
      chk("sim_if_id_flush", 32'(IF_ID_flush_o), 0);
      repeat (2) begin
         cyc(); #1;
         chk("mw_ex_mem_stall", 32'(EX_MEM_stall_o), 1);
      end
      cyc(); dmem_ready_i = 1; EX_MemRead_i = 0; #1;
      chk("rel_pc_stall", 32'(pc_stall_o), 0);
      chk("rel_ex_mem_stall", 32'(EX_MEM_stall_o), 0);
      chk("rel_if_id_flush", 32'(IF_ID_flush_o), 1);
      cyc(); idle(); #1;
      chk("mw_stall_cnt", 32'(stall_cycles_o), 4);
      chk("mw_flush_cnt", 32'(flush_count_o), 2);
      // Ready in the first cycle costs nothing.
      cyc(); MEM_MemWrite_i = 1; dmem_ready_i = 1; #1;
      chk("rdy_pc_stall", 32'(pc_stall_o), 0);
      cyc(); idle(); #1;
      chk("rdy_stall_cnt", 32'(stall_cycles_o), 4);

      // Branch after load: two bubbles, then the redirect.
      cyc(); EX_MemRead_i = 1; EX_RegWrite_i = 1; EX_rd_i = 7;
      ID_is_branch_i = 1; ID_use_rs1_i = 1; ID_rs1_i = 7; ID_use_rs2_i = 1; ID_rs2_i = 2; #1;
      chk("bl1_pc_stall", 32'(pc_stall_o), 1);
      chk("bl1_id_ex_flush", 32'(ID_EX_flush_o), 1);
      cyc(); EX_MemRead_i = 0; EX_RegWrite_i = 0; EX_rd_i = 0;
      MEM_MemRead_i = 1; MEM_RegWrite_i = 1; MEM_rd_i = 7; #1;
      chk("bl2_pc_stall", 32'(pc_stall_o), 1);
      chk("bl2_if_id_stall", 32'(IF_ID_stall_o), 1);
      chk("bl2_id_ex_flush", 32'(ID_EX_flush_o), 1);
      cyc(); MEM_MemRead_i = 0; MEM_RegWrite_i = 0; MEM_rd_i = 0;
      WB_RegWrite_i = 1; WB_rd_i = 7; ID_PCSrc_i = 1; #1;
      chk("bl3_pc_stall", 32'(pc_stall_o), 0);
      chk("bl3_if_id_flush", 32'(IF_ID_flush_o), 1);
      cyc(); idle(); #1;
      chk("bl_stall_cnt", 32'(stall_cycles_o), 6);
      chk("bl_flush_cnt", 32'(flush_count_o), 5);

      // Branch on an EX ALU result: one bubble.
      cyc(); EX_RegWrite_i = 1; EX_rd_i = 9; ID_is_branch_i = 1; ID_use_rs2_i = 1; ID_rs2_i = 9; #1;
      chk("ba1_pc_stall", 32'(pc_stall_o), 1);
      cyc(); EX_RegWrite_i = 0; EX_rd_i = 0; MEM_RegWrite_i = 1; MEM_rd_i = 9; ID_PCSrc_i = 1; #1;
      chk("ba2_pc_stall", 32'(pc_stall_o), 0);
      chk("ba2_if_id_flush", 32'(IF_ID_flush_o), 1);
      // Non-hazards: non-branch ALU dependency, x0 load, unused source.
      cyc(); idle(); EX_RegWrite_i = 1; EX_rd_i = 9; ID_use_rs2_i = 1; ID_rs2_i = 9; #1;
      chk("nb_pc_stall", 32'(pc_stall_o), 0);
      cyc(); idle(); EX_MemRead_i = 1; EX_rd_i = 0; ID_use_rs1_i = 1; ID_rs1_i = 0; #1;
      chk("x0_pc_stall", 32'(pc_stall_o), 0);
      cyc(); idle(); EX_MemRead_i = 1; EX_rd_i = 5; ID_rs1_i = 5; #1;
      chk("unused_pc_stall", 32'(pc_stall_o), 0);
      cyc(); idle(); #1;
      chk("ba_stall_cnt", 32'(stall_cycles_o), 7);
      chk("ba_flush_cnt", 32'(flush_count_o), 7);

      // Timeout after TO consecutive not-ready cycles.
      for (int i = 1; i <= TO; i++) begin
         cyc(); idle(); MEM_MemRead_i = 1; dmem_ready_i = 0; #1;
         chk("to_pc_stall", 32'(pc_stall_o), 1);
         chk("to_flag_pending", 32'(mem_timeout_o), 0);
      end
      cyc(); idle(); ID_PCSrc_i = 1; #1;
      chk("halt_flag", 32'(mem_timeout_o), 1);
      chk("halt_pc_stall", 32'(pc_stall_o), 1);
      chk("halt_if_id_flush", 32'(IF_ID_flush_o), 0);
      for (int i = 0; i < 249; i++) begin
         cyc(); ID_PCSrc_i = i[0];
      end
      // 7 + 4 + 1 + 249 = 261 stall cycles, wraps to 5 in 8 bits.
      cyc(); #1;
      chk("wrap_stall_cnt", 32'(stall_cycles_o), 5);
      chk("wrap_flush_cnt", 32'(flush_count_o), 7);
      chk("wrap_pc_stall", 32'(pc_stall_o), 1);

      // Reset out of HALT.
      cyc(); rst = 1; MEM_MemRead_i = 1; dmem_ready_i = 0;
      EX_MemRead_i = 1; EX_rd_i = 5; ID_use_rs1_i = 1; ID_rs1_i = 5; ID_PCSrc_i = 1; #1;
      chk("hr_pc_stall", 32'(pc_stall_o), 0);
      chk("hr_mem_wb_flush", 32'(MEM_WB_flush_o), 0);
      chk("hr_if_id_flush", 32'(IF_ID_flush_o), 0);
      chk("hr_ex_mem_stall", 32'(EX_MEM_stall_o), 0);
      cyc(); rst = 0; idle(); #1;
      chk("hr_timeout", 32'(mem_timeout_o), 0);
      chk("hr_stall_cnt", 32'(stall_cycles_o), 0);
      chk("hr_flush_cnt", 32'(flush_count_o), 0);
      chk("hr_pc_stall_after", 32'(pc_stall_o), 0);
      cyc(); EX_MemRead_i = 1; EX_rd_i = 5; ID_use_rs1_i = 1; ID_rs1_i = 5; #1;
      chk("post_pc_stall", 32'(pc_stall_o), 1);
      cyc(); idle(); #1;
      chk("post_stall_cnt", 32'(stall_cycles_o), 1);

      // Reset in MEM_WAIT returns to RUN: not-ready without a request must not stall.
      cyc(); MEM_MemRead_i = 1; dmem_ready_i = 0;
      cyc();
      cyc(); rst = 1; #1;
      chk("rw_rst_pc_stall", 32'(pc_stall_o), 0);
      cyc(); rst = 0; idle(); dmem_ready_i = 0; #1;
      chk("rw_pc_stall", 32'(pc_stall_o), 0);
      cyc(); idle();
      cyc();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pipeline_controller.md
# pipeline_controller

Central hazard and sequencing controller for the 5-stage core: it drives stall/flush enables of all four pipeline registers and the PC, selects EX operand forwarding, and freezes the pipeline while the data memory is not ready. Hooks into the core between the pipeline registers and the data-memory handshake. A 3-state FSM handles memory wait, timeout and halt. Counters expose stall and flush activity for debug.

## Interface
Parameters:
- MEM_TIMEOUT, 64: maximum consecutive wait cycles before halting.
- CNT_WIDTH, 32: width of the performance counters.

Ports:
- clk  in  1  core clock.
- rst  in  1  one clock; reset is synchronous and active-high.
- ID_rs1_i, ID_rs2_i  in  5 each  source registers of the ID instruction.
- ID_use_rs1_i, ID_use_rs2_i  in  1 each  ID instruction reads rs1/rs2.
- ID_is_branch_i  in  1  ID instruction is a branch or JALR, resolved in ID.
- ID_PCSrc_i  in  1  ID redirects the PC this cycle.
- EX_rs1_i, EX_rs2_i, EX_rd_i  in  5 each.
- EX_RegWrite_i, EX_MemRead_i  in  1 each.
- MEM_rd_i  in  5.
- MEM_RegWrite_i, MEM_MemRead_i, MEM_MemWrite_i  in  1 each.
- WB_rd_i  in  5.
- WB_RegWrite_i  in  1.
- dmem_ready_i  in  1  data memory completes the current MEM access.
- pc_stall_o, IF_ID_stall_o, ID_EX_stall_o, EX_MEM_stall_o  out  1 each  hold register.
- IF_ID_flush_o, ID_EX_flush_o, MEM_WB_flush_o  out  1 each  load a bubble (all control bits 0).
- EX_forwardA_o, EX_forwardB_o  out  2 each  forwarding select: 00 NONE, 01 MEM, 10 WB.
- mem_timeout_o  out  1  sticky timeout flag.
- stall_cycles_o, flush_count_o  out  CNT_WIDTH each.

## Operation
- FSM states: RUN, MEM_WAIT, HALT.
- Define mem_req = MEM_MemRead_i | MEM_MemWrite_i. A register match requires rd != 0.
- RUN, evaluated in priority order:
  1. mem_req && !dmem_ready_i: assert all four stalls and MEM_WB_flush_o, and go to MEM_WAIT with wait_cnt = 1.
  2. Load-use hazard: EX_MemRead_i and EX_rd_i matches a used ID source. Assert pc_stall_o, IF_ID_stall_o and ID_EX_flush_o.
  3. Branch data hazard: ID_is_branch_i and a used ID source matches either (EX_RegWrite_i, EX_rd_i) or (MEM_RegWrite_i && MEM_MemRead_i, MEM_rd_i). Action is the same as for a load-use hazard.
  4. ID_PCSrc_i: assert IF_ID_flush_o.
- MEM_WAIT:
  - All four stalls and MEM_WB_flush_o stay high while !dmem_ready_i, and wait_cnt increments.
  - When dmem_ready_i is seen: release for this cycle (outputs as in RUN priority 2-4, ignoring rule 1) and go to RUN.
  - When wait_cnt == MEM_TIMEOUT and not ready: set mem_timeout_o and go to HALT.
- HALT: all stalls and MEM_WB_flush_o stay high permanently. Only rst exits HALT.
- Forwarding applies to operand A using EX_rs1_i; B is identical using EX_rs2_i:
  - MEM (01) if MEM_RegWrite_i && !MEM_MemRead_i && MEM_rd_i == EX_rs1_i != 0.
  - Otherwise WB (10) if WB_RegWrite_i && WB_rd_i == EX_rs1_i != 0.
  - Otherwise NONE.
  - MEM has priority over WB. Forwarding outputs are combinational in every state.
- The register file is write-first, so WB needs no ID hazard check.
- stall_cycles_o increments every cycle in which pc_stall_o = 1.
- flush_count_o increments every cycle in which IF_ID_flush_o or ID_EX_flush_o = 1; it counts +1 even if both are high.
- Both counters wrap modulo 2^CNT_WIDTH.

## Timing
- Reset (synchronous, rst high at a clock edge):
  - State becomes RUN; wait_cnt, counters and mem_timeout_o become 0.
  - While rst is high, all stall and flush outputs are 0 and forwards are NONE.
  - rst asserted in MEM_WAIT or HALT returns to RUN on the next edge.
- Stall/flush outputs are combinational from the current state and inputs; they take effect at the next clk edge.
- A load-use hazard costs exactly 1 bubble.
- A branch depending on an EX ALU result costs 1 bubble.
- A branch depending on a load in EX costs 2 bubbles: load-use, then the MEM-load rule.
- Memory wait of N not-ready cycles costs N stall cycles. A ready in the first cycle costs 0.
- Simultaneous events:
  - A memory stall masks a hazard or ID_PCSrc_i in the same cycle; the ID redirect is re-evaluated after release.
  - A hazard stall suppresses IF_ID_flush_o, because the branch is not yet resolved.
- Counters update on the edge following the qualifying cycle.

## Test plan
- Load-use: lw x5 in EX (EX_MemRead=1, EX_rd=5), ID reads rs1=5 -> pc_stall=IF_ID_stall=ID_EX_flush=1 for exactly 1 cycle; stall_cycles_o=1, flush_count_o=1.
- Forwarding: EX_rs1=3, EX_rs2=3, MEM_rd=3, WB_rd=3, both RegWrite -> forwardA=forwardB=01. With MEM_RegWrite=0 -> 10. With rd=0 -> 00.
- Memory wait: MEM_MemRead=1, dmem_ready low 3 cycles then high -> all stalls high for 3 cycles, released on the ready cycle, state returns to RUN; stall_cycles_o=3.
- Timeout: MEM_TIMEOUT=4, dmem_ready held low -> mem_timeout_o=1 after 4 wait cycles, stalls stuck high. Then rst high 1 cycle -> all outputs 0, state RUN.
- Branch after load: beq using x7, lw x7 in EX -> 2 stall cycles, then ID_PCSrc=1 -> IF_ID_flush_o=1 for 1 cycle; flush_count_o=3.
- Simultaneous: mem not ready, load-use and ID_PCSrc all active -> only memory stall outputs asserted; ID_EX_flush_o=0, IF_ID_flush_o=0.
